aclk_keypad_scanner: RTL and testbench

//  Scans a 4x3 matrix keypad, synchronises and debounces the row returns, and emits the
//  4-bit key code consumed by the alarm-clock controller's key input. Digits 0-9 give

---
 rtl/aclk_keypad_scanner.sv | 166 ++++++++++++++++
 tb/tb_aclk_keypad_scanner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/aclk_keypad_scanner.sv
// Scans a 4x3 keypad and produces a debounced digit code for the alarm clock.
// Ports: clock, reset (async, active-high), scan_tick (pacing pulse),
//        row_sense[3:0] (raw rows), col_drive[2:0] (one-hot columns),
//        key[3:0] (0-9 or NOKEY), key_strobe (one-clock new-press pulse).
// Option: define KEYPAD_GHOST_REJECT_EN to decode multi-row readings as NOKEY;
//         otherwise the lowest-index active row wins.
module aclk_keypad_scanner #(
    parameter int         DEBOUNCE_CNT = 4,
    parameter logic [3:0] NOKEY        = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scan_tick,
    input  logic [3:0] row_sense,
    output logic [2:0] col_drive,
    output logic [3:0] key,
    output logic       key_strobe
);

    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CNT);
    // The first non-matching tick is taken in HELD, so RELEASE
    // finishes one count earlier than DEBOUNCE does.
    localparam int REL_LAST = DEBOUNCE_CNT - 2;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    row_m_q, row_s_q;
    logic [2:0]    col_q, col_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_q, key_d;
    logic          strobe_q, strobe_d;

    logic [1:0]    row_idx;
    logic [1:0]    col_idx;
    logic [3:0]    decode;
`ifdef KEYPAD_GHOST_REJECT_EN
    logic          multi_row;
`endif

    always_comb begin
        row_idx = 2'd0;
        if (row_s_q[0])      row_idx = 2'd0;
        else if (row_s_q[1]) row_idx = 2'd1;
        else if (row_s_q[2]) row_idx = 2'd2;
        else if (row_s_q[3]) row_idx = 2'd3;

        col_idx = 2'd0;
        if (col_q[1])      col_idx = 2'd1;
        else if (col_q[2]) col_idx = 2'd2;

        decode = NOKEY;
        if (row_s_q != 4'd0) begin
            if (row_idx != 2'd3) begin
                decode = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
            end else if (col_idx == 2'd1) begin
                decode = 4'd0;
            end
        end

`ifdef KEYPAD_GHOST_REJECT_EN
        multi_row = (row_s_q[0] & row_s_q[1]) | (row_s_q[0] & row_s_q[2]) |
                    (row_s_q[0] & row_s_q[3]) | (row_s_q[1] & row_s_q[2]) |
                    (row_s_q[1] & row_s_q[3]) | (row_s_q[2] & row_s_q[3]);
        if (multi_row) decode = NOKEY;
`endif
    end

    assign cnt_inc = (cnt_q >= CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        key_d    = key_q;
        strobe_d = 1'b0;

        if (scan_tick) begin
            unique case (state_q)
                SCAN: begin
                    if (decode != NOKEY) begin
                        cand_d  = decode;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = {col_q[1:0], col_q[2]};
                    end
                end
                DEBOUNCE: begin
                    if (decode == cand_q) begin
                        if (cnt_q >= CNT_LAST) begin
                            state_d  = HELD;
                            key_d    = cand_q;
                            strobe_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = SCAN;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (decode != cand_q) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end
                end
                RELEASE: begin
                    if (decode == cand_q) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (int'(cnt_q) >= REL_LAST) begin
                        state_d = SCAN;
                        key_d   = NOKEY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_m_q  <= 4'd0;
            row_s_q  <= 4'd0;
            state_q  <= SCAN;
            col_q    <= 3'b001;
            cnt_q    <= '0;
            cand_q   <= NOKEY;
            key_q    <= NOKEY;
            strobe_q <= 1'b0;
        end else begin
            row_m_q  <= row_sense;
            row_s_q  <= row_m_q;
            state_q  <= state_d;
            col_q    <= col_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            key_q    <= key_d;
            strobe_q <= strobe_d;
        end
    end

    assign col_drive  = col_q;
    assign key        = key_q;
    assign key_strobe = strobe_q;

endmodule

// File: tb/tb_aclk_keypad_scanner.sv
// Bench for aclk_keypad_scanner: a keypad model answers col_drive,
// expected strobed codes go through a queue checked by a monitor.
module tb_aclk_keypad_scanner;

    localparam int DB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scan_tick = 1'b0;
    logic [3:0] row_sense;
    logic [2:0] col_drive;
    logic [3:0] key;
    logic       key_strobe;

    logic       press_en = 1'b0;
    logic [3:0] press_rows = 4'd0;
    logic [2:0] press_col = 3'b001;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];
    logic prev_strobe = 1'b0;

    aclk_keypad_scanner #(.DEBOUNCE_CNT(DB), .NOKEY(4'd10)) dut (
        .clock(clock),
        .reset(reset),
        .scan_tick(scan_tick),
        .row_sense(row_sense),
        .col_drive(col_drive),
        .key(key),
        .key_strobe(key_strobe)
    );

    always #5 clock = ~clock;

    assign row_sense = (press_en && (col_drive & press_col) != 3'd0)
                       ? press_rows : 4'd0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            prev_strobe <= 1'b0;
        end else begin
            if (key_strobe) begin
                chk("strobe_back_to_back", int'(prev_strobe), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe_key", int'(key), -1);
                end else begin
                    chk("strobe_key", int'(key), int'(exp_q.pop_front()));
                end
            end
            prev_strobe <= key_strobe;
        end
    end

    task automatic do_tick();
        repeat (3) @(negedge clock);
        scan_tick = 1'b1;
        @(negedge clock);
        scan_tick = 1'b0;
    endtask

    task automatic goto_col(input int c);
        int guard;
        guard = 0;
        while (col_drive != 3'(1 << c) && guard < 4) begin
            do_tick();
            guard++;
        end
        chk("goto_col", int'(col_drive), 1 << c);
    endtask

    task automatic press(input logic [3:0] rows, input logic [2:0] col);
        press_rows = rows;
        press_col  = col;
        press_en   = 1'b1;
    endtask

    task automatic accept(input logic [3:0] code, input string name);
        exp_q.push_back(code);
        do_tick();
        repeat (DB - 1) do_tick();
        chk({name, "_pre"}, int'(key), 10);
        do_tick();
        chk(name, int'(key), int'(code));
    endtask

    task automatic release_key(input logic [3:0] code, input string name);
        press_en = 1'b0;
        repeat (DB - 1) do_tick();
        chk({name, "_still"}, int'(key), int'(code));
        do_tick();
        chk(name, int'(key), 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_col", int'(col_drive), 1);
        chk("rst_key", int'(key), 10);
        chk("rst_strobe", int'(key_strobe), 0);
        do_tick();
        chk("rot_1", int'(col_drive), 2);
        do_tick();
        chk("rot_2", int'(col_drive), 4);
        do_tick();
        chk("rot_3", int'(col_drive), 1);

        goto_col(1);
        press(4'b0010, 3'b010);
        accept(4'd5, "key5");
        chk("strobe_hi", int'(key_strobe), 1);
        @(negedge clock);
        chk("strobe_lo", int'(key_strobe), 0);
        release_key(4'd5, "rel5");

        goto_col(2);
        press(4'b0100, 3'b100);
        do_tick();
        do_tick();
        press_en = 1'b0;
        do_tick();
        chk("bounce_key", int'(key), 10);
        chk("bounce_col_hold", int'(col_drive), 4);
        do_tick();
        chk("bounce_rotate", int'(col_drive), 1);

        press(4'b1000, 3'b001);
        do_tick();
        chk("star_key", int'(key), 10);
        chk("star_rotate", int'(col_drive), 2);
        do_tick();
        do_tick();
        chk("star_wrap", int'(col_drive), 1);
        press(4'b1000, 3'b100);
        repeat (3) do_tick();
        chk("hash_key", int'(key), 10);
        chk("hash_wrap", int'(col_drive), 1);
        press_en = 1'b0;

        goto_col(0);
        press(4'b0011, 3'b001);
`ifdef KEYPAD_GHOST_REJECT_EN
        repeat (DB + 1) do_tick();
        chk("ghost_key", int'(key), 10);
        chk("ghost_scan", int'(col_drive), 4);
        press_en = 1'b0;
`else
        accept(4'd1, "multi_row");
        release_key(4'd1, "rel1");
`endif

        goto_col(0);
        press(4'b0100, 3'b001);
        accept(4'd7, "key7");
        press_en = 1'b0;
        do_tick();
        chk("dropout", int'(key), 7);
        press_en = 1'b1;
        do_tick();
        chk("dropout_back", int'(key), 7);
        repeat (2) do_tick();
        chk("held_again", int'(key), 7);

        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midrst_key", int'(key), 10);
        chk("midrst_col", int'(col_drive), 1);
        chk("midrst_strobe", int'(key_strobe), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        accept(4'd7, "redetect7");
        release_key(4'd7, "rel7");

        repeat (4) @(negedge clock);
        chk("pending_strobes", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
